// File: rtl/cla_subtractor_5bit.sv
// cla_subtractor_5bit: two-stage pipelined 5-bit subtractor (diff = a - b mod 32)
// built on a carry-lookahead core, with a valid/ready stream handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair this cycle (combinational)
//   a, b       minuend / subtrahend
//   out_valid  diff and flags are valid
//   out_ready  consumer takes the result this cycle
//   diff       a - b mod 32
//   borrow     unsigned borrow (a < b)
//   ovf        signed overflow of a - b
//   zero       diff == 0
module cla_subtractor_5bit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  // Stage 1: generate/propagate of a + ~b, plus operand sign bits
  logic [WIDTH-1:0] g1_q;
  logic [WIDTH-1:0] p1_q;
  logic             sa1_q;
  logic             sb1_q;
  logic             v1_q;

  // Stage 2 valid; the result fields are the output registers themselves
  logic             v2_q;

  logic             adv2_c;
  logic [WIDTH:0]   c_c;
  logic [WIDTH-1:0] d_c;
  logic             ovf_c;

  // Handshake: S2 drains when empty or consumed; S1 loads when S2 makes room
  assign adv2_c    = ~v2_q | out_ready;
  assign in_ready  = ~v1_q | adv2_c;
  assign out_valid = v2_q;

  // Two-level lookahead carries with carry-in 1 (the +1 of two's complement)
  always_comb begin
    c_c    = '0;
    c_c[0] = 1'b1;
    c_c[1] = g1_q[0] | p1_q[0];
    c_c[2] = g1_q[1] | (p1_q[1] & g1_q[0]) | (p1_q[1] & p1_q[0]);
    c_c[3] = g1_q[2] | (p1_q[2] & g1_q[1]) | (p1_q[2] & p1_q[1] & g1_q[0])
           | (p1_q[2] & p1_q[1] & p1_q[0]);
    c_c[4] = g1_q[3] | (p1_q[3] & g1_q[2]) | (p1_q[3] & p1_q[2] & g1_q[1])
           | (p1_q[3] & p1_q[2] & p1_q[1] & g1_q[0])
           | (p1_q[3] & p1_q[2] & p1_q[1] & p1_q[0]);
    c_c[5] = g1_q[4] | (p1_q[4] & g1_q[3]) | (p1_q[4] & p1_q[3] & g1_q[2])
           | (p1_q[4] & p1_q[3] & p1_q[2] & g1_q[1])
           | (p1_q[4] & p1_q[3] & p1_q[2] & p1_q[1] & g1_q[0])
           | (&p1_q);
  end

  assign d_c   = p1_q ^ c_c[WIDTH-1:0];
  // Overflow only possible when operand signs differ and result sign flips from a
  assign ovf_c = (sa1_q ^ sb1_q) & (d_c[WIDTH-1] ^ sa1_q);

  // Stage 1 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1_q  <= '0;
      p1_q  <= '0;
      sa1_q <= 1'b0;
      sb1_q <= 1'b0;
      v1_q  <= 1'b0;
    end else if (in_ready) begin
      g1_q  <= a & ~b;
      p1_q  <= a ^ ~b;
      sa1_q <= a[WIDTH-1];
      sb1_q <= b[WIDTH-1];
      v1_q  <= in_valid;
    end
  end

  // Stage 2 register (outputs); holds while a valid result is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      v2_q   <= 1'b0;
    end else if (adv2_c) begin
      diff   <= d_c;
      borrow <= ~c_c[WIDTH];
      ovf    <= ovf_c;
      zero   <= ~|d_c;
      v2_q   <= v1_q;
    end
  end

endmodule

// File: tb/tb_cla_subtractor_5bit.sv
// Self-checking bench for cla_subtractor_5bit: expected results are queued on
// input accept and compared whenever the DUT presents a valid result.
module tb_cla_subtractor_5bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;
  logic       borrow;
  logic       ovf;
  logic       zero;

  always #5 clk = ~clk;

  cla_subtractor_5bit #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [4:0] d;
    logic       br;
    logic       ov;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_chk  = 1'b0;
  bit   mirror   = 1'b0;
  bit   acc_hist [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer subtraction, range test for signed overflow
  function automatic exp_t model(input logic [4:0] x, input logic [4:0] y);
    exp_t e;
    int ux = int'(x);
    int uy = int'(y);
    int sx = x[4] ? ux - 32 : ux;
    int sy = y[4] ? uy - 32 : uy;
    int sd = sx - sy;
    e.d   = 5'(ux - uy);
    e.br  = (ux < uy);
    e.ov  = (sd > 15) || (sd < -16);
    e.z   = (e.d == 5'd0);
    e.cyc = 0;
    return e;
  endfunction

  // One clock: compare visible result, pop on consume, push on accept
  task automatic tick();
    bit   acc;
    bit   fire;
    exp_t e;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (mirror && cyc >= 2) chk("valid_pattern", 32'(out_valid), 32'(acc_hist[cyc-2]));
    if (out_valid) begin
      chk("unexpected_result", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow", 32'(borrow), 32'(e.br));
        chk("ovf", 32'(ovf), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
        if (fire) begin
          if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
          void'(q.pop_front());
        end
      end
    end
    acc_hist[cyc] = acc;
    if (acc) begin
      e = model(a, b);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] x, input logic [4:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'd0);
    chk({tag, "_borrow"}, 32'(borrow), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) acc_hist[i] = 1'b0;

    // Reset state
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // Single operations with exact two-cycle latency
    mirror  = 1'b1;
    lat_chk = 1'b1;
    send(5'b01000, 5'b00011); idle(3);
    send(5'b00011, 5'b01000); idle(3);
    send(5'b10101, 5'b10101); idle(3);

    // Overflow / borrow corners
    send(5'b01111, 5'b10000); idle(3);
    send(5'b10000, 5'b00001); idle(3);
    send(5'b00000, 5'b11111); idle(3);

    // Streaming: five back-to-back pairs
    send(5'd3, 5'd9);
    send(5'd31, 5'd1);
    send(5'd17, 5'd17);
    send(5'd12, 5'd28);
    send(5'd20, 5'd7);
    idle(4);

    // Bubbles: alternating valid
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      tick();
    end
    idle(4);
    chk("drain_after_bubbles", 32'(q.size()), 32'd0);

    // Backpressure: three pairs, consumer stalled for four cycles
    mirror    = 1'b0;
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(5'd9, 5'd4);
    send(5'd2, 5'd30);
    in_valid = 1'b1;
    a = 5'd16;
    b = 5'd16;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("in_ready_on_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    idle(4);
    chk("drain_after_backpressure", 32'(q.size()), 32'd0);

    // Async reset with both stages full and consumer stalled
    out_ready = 1'b0;
    send(5'd5, 5'd1);
    send(5'd6, 5'd2);
    chk("prefill_valid", 32'(out_valid), 32'd1);
    chk("prefill_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("async_reset");
    q.delete();
    @(negedge clk);
    chk_reset_state("reset_held");
    rst       = 1'b1;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    idle(2);
    send(5'b00111, 5'b00010);
    idle(3);
    chk("drain_final", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
